// File: rtl/c_pipe_ctrl_chain_if.sv
// Bundle of the control-chain signals: decode-side input word, per-stage stall/flush,
// per-stage registered outputs and the performance-debug event counters.
interface c_pipe_ctrl_chain_if #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
);
  logic                      d_valid;
  logic [WIDTH-1:0]          d_ctrl;
  logic [STAGES-1:0]         stall;
  logic [STAGES-1:0]         flush;
  logic                      cnt_clr;
  logic [STAGES-1:0]         q_valid;
  logic [STAGES*WIDTH-1:0]   q_ctrl;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output d_valid, d_ctrl, stall, flush, cnt_clr,
    input  q_valid, q_ctrl, stall_cnt, flush_cnt
  );

  modport slave (
    input  d_valid, d_ctrl, stall, flush, cnt_clr,
    output q_valid, q_ctrl, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/c_pipe_ctrl_chain.sv
// Configurable chain of control-word pipeline registers with per-stage stall/flush,
// automatic bubble insertion and saturating stall/flush event counters.
module c_pipe_ctrl_chain #(
  parameter int unsigned      WIDTH        = 12,
  parameter int unsigned      STAGES       = 3,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter int unsigned      CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  c_pipe_ctrl_chain_if.slave    bus
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] valid_vec;
  logic [WIDTH-1:0]  word_vec [STAGES];

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              any_stall;
  logic              any_flush_valid;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] src_word;
    logic             src_valid;
    logic             up_hold;

    // A stall anywhere downstream freezes this stage too, so nothing is overwritten.
    assign hold[i] = |bus.stall[STAGES-1:i];

    if (i == 0) begin : g_head
      // Invalid input words are squashed so a bubble always carries BUBBLE_VALUE.
      assign src_word  = bus.d_valid ? bus.d_ctrl : BUBBLE_VALUE;
      assign src_valid = bus.d_valid;
      assign up_hold   = 1'b0;
    end else begin : g_body
      assign src_word  = word_vec[i-1];
      assign src_valid = valid_vec[i-1];
      assign up_hold   = hold[i-1];
    end

    always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      if (bus.flush[i]) begin
        word_d  = BUBBLE_VALUE;
        valid_d = 1'b0;
      end else if (!hold[i]) begin
        // Upstream frozen while this stage drains: insert a bubble behind it.
        if (up_hold) begin
          word_d  = BUBBLE_VALUE;
          valid_d = 1'b0;
        end else begin
          word_d  = src_word;
          valid_d = src_valid;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q  <= BUBBLE_VALUE;
        valid_q <= 1'b0;
      end else begin
        word_q  <= word_d;
        valid_q <= valid_d;
      end
    end

    assign word_vec[i]                      = word_q;
    assign valid_vec[i]                     = valid_q;
    assign bus.q_ctrl[i*WIDTH +: WIDTH]     = word_q;
    assign bus.q_valid[i]                   = valid_q;
  end

  assign any_stall       = |bus.stall;
  assign any_flush_valid = |(bus.flush & valid_vec);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (any_stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (any_flush_valid && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
